// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Fixed-latency word load/store responder behind a valid/ready
//            request/response handshake; bad addresses get an error response.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic             addr_err;
  logic             do_access;

  // Range check uses the full word index so high address bits can never alias.
  assign idx       = lat_addr[IDX_W+1:2];
  assign addr_err  = (lat_addr[1:0] != 2'b00) ||
                     ({2'b00, lat_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign do_access = (state == BUSY) && (cnt == 4'd0);

  // Handshake flags depend on state alone: no input-to-output paths.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // Storage carries no reset; an asynchronous reset forces IDLE, which
  // deasserts do_access and so cancels any pending store.
  always_ff @(posedge clk) begin
    if (do_access && lat_write && !addr_err) begin
      mem[idx] <= lat_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_write  <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cnt       <= CNT_INIT;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_error <= addr_err;
            resp_rdata <= (!addr_err && !lat_write) ? mem[idx] : 32'd0;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed bench for dmem_responder at LATENCY 2, 1 and 15.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_error [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0: LATENCY 2, instance 1: LATENCY 1, instance 2: LATENCY 15.
  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    ((g == 0) ? 2 : ((g == 1) ? 1 : 15))
      ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid[g]),
        .req_ready (req_ready[g]),
        .req_write (req_write[g]),
        .req_addr  (req_addr[g]),
        .req_wdata (req_wdata[g]),
        .resp_valid(resp_valid[g]),
        .resp_ready(resp_ready[g]),
        .resp_rdata(resp_rdata[g]),
        .resp_error(resp_error[g])
      );
    end
  endgenerate

  function automatic int lat(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with resp_ready held high from the start.
  task automatic do_req(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input string name);
    int l;
    l = lat(d);
    checks++;
    if (req_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_ready: got %b want 1", name, req_ready[d]);
    end
    req_valid[d]  = 1'b1;
    req_write[d]  = wr;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    resp_ready[d] = 1'b1;
    step();
    req_valid[d] = 1'b0;
    req_write[d] = ~wr;
    req_addr[d]  = 32'hFFFF_FFFF;
    req_wdata[d] = 32'h5555_5555;
    checks++;
    if (req_ready[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_after_accept: got %b want 0", name, req_ready[d]);
    end
    for (int k = 0; k < l; k++) begin
      checks++;
      if (resp_valid[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s early_valid edge N+%0d: got %b want 0", name, k, resp_valid[d]);
      end
      if (k < l - 1) step();
    end
    step();
    checks++;
    if (resp_valid[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s resp_valid at N+%0d: got %b want 1", name, l, resp_valid[d]);
    end
    checks++;
    if (resp_rdata[d] !== exp_rdata) begin
      errors++;
      $display("FAIL %s rdata: got %h want %h", name, resp_rdata[d], exp_rdata);
    end
    checks++;
    if (resp_error[d] !== exp_err) begin
      errors++;
      $display("FAIL %s error: got %b want %b", name, resp_error[d], exp_err);
    end
    step();
    checks++;
    if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1 || resp_rdata[d] !== 32'd0) begin
      errors++;
      $display("FAIL %s after_consume: valid=%b ready=%b rdata=%h want 0 1 0",
               name, resp_valid[d], req_ready[d], resp_rdata[d]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req_valid[d]  = 1'b0;
      req_write[d]  = 1'b0;
      req_addr[d]   = 32'd0;
      req_wdata[d]  = 32'd0;
      resp_ready[d] = 1'b0;
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 ||
          resp_rdata[d] !== 32'd0 || resp_error[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d: ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
                 d, req_ready[d], resp_valid[d], resp_rdata[d], resp_error[d]);
      end
    end
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_store_load();
    do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0, "store_10");
    do_req(0, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, "load_10");
  endtask

  task automatic test_backpressure();
    req_valid[0]  = 1'b1;
    req_write[0]  = 1'b0;
    req_addr[0]   = 32'h10;
    resp_ready[0] = 1'b0;
    step();
    req_valid[0] = 1'b0;
    step();
    step();
    checks++;
    if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL hold_first: valid=%b rdata=%h want 1 deadbeef", resp_valid[0], resp_rdata[0]);
    end
    // Stray store requests while the response is pending must be ignored.
    for (int k = 0; k < 5; k++) begin
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 32'h10;
      req_wdata[0] = 32'h0BAD_0BAD;
      step();
      checks++;
      if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 32'hDEAD_BEEF ||
          resp_error[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b rdata=%h err=%b ready=%b want 1 deadbeef 0 0",
                 k, resp_valid[0], resp_rdata[0], resp_error[0], req_ready[0]);
      end
    end
    req_valid[0]  = 1'b0;
    req_write[0]  = 1'b0;
    resp_ready[0] = 1'b1;
    step();
    checks++;
    if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || resp_rdata[0] !== 32'd0) begin
      errors++;
      $display("FAIL hold_release: valid=%b ready=%b rdata=%h want 0 1 0",
               resp_valid[0], req_ready[0], resp_rdata[0]);
    end
  endtask

  task automatic test_errors();
    do_req(0, 1'b1, 32'h13, 32'h1234_5678, 32'd0, 1'b1, "misaligned_store");
    do_req(0, 1'b1, 32'(4 * DEPTH), 32'h1234_5678, 32'd0, 1'b1, "oor_store");
    do_req(0, 1'b0, 32'h4000_0010, 32'd0, 32'd0, 1'b1, "oor_load_alias");
    do_req(0, 1'b0, 32'(4 * DEPTH - 4), 32'd0, 32'hXXXX_XXXX, 1'b0, "last_word_load_dummy");
  endtask

  task automatic test_last_word();
    do_req(0, 1'b1, 32'(4 * DEPTH - 4), 32'h7777_1111, 32'd0, 1'b0, "last_word_store");
    do_req(0, 1'b0, 32'(4 * DEPTH - 4), 32'd0, 32'h7777_1111, 1'b0, "last_word_load");
    do_req(0, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, "load_10_after_errors");
  endtask

  task automatic test_reset_mid_op();
    do_req(0, 1'b1, 32'h20, 32'h1, 32'd0, 1'b0, "store_20_init");
    req_valid[0]  = 1'b1;
    req_write[0]  = 1'b1;
    req_addr[0]   = 32'h20;
    req_wdata[0]  = 32'hCAFE_F00D;
    resp_ready[0] = 1'b1;
    step();
    req_valid[0] = 1'b0;
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0 ||
        resp_rdata[0] !== 32'd0 || resp_error[0] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
               req_ready[0], resp_valid[0], resp_rdata[0], resp_error[0]);
    end
    step();
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
        errors++;
        $display("FAIL midreset_no_resp cycle%0d: valid=%b ready=%b want 0 1",
                 k, resp_valid[0], req_ready[0]);
      end
    end
    do_req(0, 1'b0, 32'h20, 32'd0, 32'h1, 1'b0, "load_20_after_reset");
  endtask

  task automatic test_back_to_back();
    do_req(1, 1'b1, 32'h0, 32'hA5A5_A5A5, 32'd0, 1'b0, "lat1_store");
    do_req(1, 1'b0, 32'h0, 32'd0, 32'hA5A5_A5A5, 1'b0, "lat1_load");
    do_req(2, 1'b1, 32'h0, 32'hA5A5_A5A5, 32'd0, 1'b0, "lat15_store");
    do_req(2, 1'b0, 32'h0, 32'd0, 32'hA5A5_A5A5, 1'b0, "lat15_load");
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_backpressure();
    do_req(0, 1'b1, 32'h13, 32'h1234_5678, 32'd0, 1'b1, "misaligned_store");
    do_req(0, 1'b1, 32'(4 * DEPTH), 32'h1234_5678, 32'd0, 1'b1, "oor_store");
    do_req(0, 1'b0, 32'h4000_0010, 32'd0, 32'd0, 1'b1, "oor_load_alias");
    test_last_word();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
